// File: rtl/tq_pll_pkg.sv
// tq_pll_pkg: shared constants and helpers for the tq_pll clock generator.
//   - DefaultAccWidth          : default phase-accumulator width
//   - Min/Max AccWidth         : legal accumulator widths
//   - Min/Max LockCycles       : legal lock-count range
//   - freq_word_max(acc_width) : largest legal FREQ_WORD (f_ref/2)
//   - lock_cnt_width(cycles)   : bits needed to count 0..cycles
package tq_pll_pkg;

    localparam int unsigned DefaultAccWidth = 32;
    localparam int unsigned MinAccWidth     = 8;
    localparam int unsigned MaxAccWidth     = 48;
    localparam int unsigned MinLockCycles   = 1;
    localparam int unsigned MaxLockCycles   = 65535;

    function automatic longint unsigned freq_word_max(input int unsigned acc_width);
        return 64'd1 << (acc_width - 1);
    endfunction

    function automatic int unsigned lock_cnt_width(input int unsigned lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/tq_pll_nco.sv
// tq_pll_nco: phase-accumulator NCO producing a square wave and its rising-edge strobe.
// Ports:
//   refclk       in  reference clock, all state on posedge
//   rst          in  synchronous active-high reset, loads PHASE_OFFSET
//   outclk       out accumulator MSB (direct flop output)
//   outclk_rise  out high in the cycle outclk has just gone 0->1
module tq_pll_nco
    import tq_pll_pkg::*;
#(
    parameter int unsigned     ACC_WIDTH    = DefaultAccWidth,
    parameter longint unsigned FREQ_WORD    = freq_word_max(ACC_WIDTH),
    parameter longint unsigned PHASE_OFFSET = 0
) (
    input  logic refclk,
    input  logic rst,
    output logic outclk,
    output logic outclk_rise
);

    localparam logic [ACC_WIDTH-1:0] Inc       = ACC_WIDTH'(FREQ_WORD);
    localparam logic [ACC_WIDTH-1:0] ResetAcc  = ACC_WIDTH'(PHASE_OFFSET);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 rise_q, rise_d;

    // Modulo-2^ACC_WIDTH wrap is implicit in the fixed-width add.
    always_comb begin
        acc_d  = acc_q + Inc;
        rise_d = !acc_q[ACC_WIDTH-1] && acc_d[ACC_WIDTH-1];
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            acc_q  <= ResetAcc;
            rise_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rise_q <= rise_d;
        end
    end

    assign outclk      = acc_q[ACC_WIDTH-1];
    assign outclk_rise = rise_q;

endmodule

// File: rtl/tq_pll.sv
// tq_pll: synthesizable stand-in for the vendor PLL, running entirely in the refclk domain.
// Ports:
//   refclk         in  reference clock
//   rst            in  synchronous active-high reset
//   outclk_0       out derived clock, f_ref*FREQ_WORD/2^ACC_WIDTH
//   outclk_0_rise  out one-cycle strobe when outclk_0 has just risen
//   locked         out sticky lock flag, set after LOCK_CYCLES output rising edges
module tq_pll
    import tq_pll_pkg::*;
#(
    parameter int unsigned     ACC_WIDTH    = DefaultAccWidth,
    parameter longint unsigned FREQ_WORD    = freq_word_max(ACC_WIDTH),
    parameter longint unsigned PHASE_OFFSET = 0,
    parameter int unsigned     LOCK_CYCLES  = 16
) (
    input  logic refclk,
    input  logic rst,
    output logic outclk_0,
    output logic outclk_0_rise,
    output logic locked
);

    localparam int unsigned          CntWidth = lock_cnt_width(LOCK_CYCLES);
    localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(LOCK_CYCLES);

    if (ACC_WIDTH < MinAccWidth || ACC_WIDTH > MaxAccWidth) begin : g_bad_acc_width
        $error("tq_pll: ACC_WIDTH out of range");
    end
    if (FREQ_WORD > freq_word_max(ACC_WIDTH)) begin : g_bad_freq_word
        $error("tq_pll: FREQ_WORD above 2**(ACC_WIDTH-1)");
    end
    if (LOCK_CYCLES < MinLockCycles || LOCK_CYCLES > MaxLockCycles) begin : g_bad_lock_cycles
        $error("tq_pll: LOCK_CYCLES out of range");
    end

    tq_pll_nco #(
        .ACC_WIDTH    (ACC_WIDTH),
        .FREQ_WORD    (FREQ_WORD),
        .PHASE_OFFSET (PHASE_OFFSET)
    ) u_nco (
        .refclk      (refclk),
        .rst         (rst),
        .outclk      (outclk_0),
        .outclk_rise (outclk_0_rise)
    );

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                locked_q, locked_d;

    // locked is taken from the next counter value so it sets on the same edge
    // that counts the LOCK_CYCLES-th strobe, one cycle after that strobe.
    always_comb begin
        cnt_d = cnt_q;
        if (outclk_0_rise && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
        locked_d = locked_q || (cnt_d == CntMax);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_tq_pll.sv
// tb_tq_pll: drives several tq_pll configurations from one clock and reset and checks them
// against an arithmetic phase-accumulator model plus hand-derived waveform expectations.
module tb_tq_pll;

    localparam int N = 6;
    // 0 half-rate, 1 quarter, 2 divide-by-3, 3 frozen, 4 phase-offset, 5 12-bit fractional
    localparam int unsigned     P_W  [N] = '{32, 32, 32, 32, 32, 12};
    localparam longint unsigned P_FW [N] = '{64'h8000_0000, 64'h4000_0000, 64'h5555_5555,
                                             64'h0, 64'h8000_0000, 64'd1234};
    localparam longint unsigned P_PO [N] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0000,
                                             64'd300};
    localparam int              P_LC [N] = '{4, 4, 16, 16, 4, 5};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [N-1:0] oc, rs, lk;

    always #5 clk = ~clk;

    tq_pll #(.FREQ_WORD(64'h8000_0000), .LOCK_CYCLES(4)) d_half (
        .refclk(clk), .rst(rst), .outclk_0(oc[0]), .outclk_0_rise(rs[0]), .locked(lk[0]));
    tq_pll #(.FREQ_WORD(64'h4000_0000), .LOCK_CYCLES(4)) d_quarter (
        .refclk(clk), .rst(rst), .outclk_0(oc[1]), .outclk_0_rise(rs[1]), .locked(lk[1]));
    tq_pll #(.FREQ_WORD(64'h5555_5555), .LOCK_CYCLES(16)) d_third (
        .refclk(clk), .rst(rst), .outclk_0(oc[2]), .outclk_0_rise(rs[2]), .locked(lk[2]));
    tq_pll #(.FREQ_WORD(64'h0), .LOCK_CYCLES(16)) d_zero (
        .refclk(clk), .rst(rst), .outclk_0(oc[3]), .outclk_0_rise(rs[3]), .locked(lk[3]));
    tq_pll #(.PHASE_OFFSET(64'h8000_0000), .LOCK_CYCLES(4)) d_phase (
        .refclk(clk), .rst(rst), .outclk_0(oc[4]), .outclk_0_rise(rs[4]), .locked(lk[4]));
    tq_pll #(.ACC_WIDTH(12), .FREQ_WORD(64'd1234), .PHASE_OFFSET(64'd300), .LOCK_CYCLES(5))
        d_frac (
        .refclk(clk), .rst(rst), .outclk_0(oc[5]), .outclk_0_rise(rs[5]), .locked(lk[5]));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase as an integer modulo 2^W, strobes counted as they are observed.
    longint unsigned m_acc     [N];
    bit              m_rise    [N];
    int              m_strobes [N];

    function automatic bit m_clk(input int k);
        return m_acc[k] >= (64'd1 << (P_W[k] - 1));
    endfunction

    function automatic bit m_locked(input int k);
        return m_strobes[k] >= P_LC[k];
    endfunction

    task automatic model_step(input bit r);
        for (int k = 0; k < N; k++) begin
            longint unsigned modulus;
            bit              was_high;
            modulus = 64'd1 << P_W[k];
            if (r) begin
                m_acc[k]     = P_PO[k] % modulus;
                m_rise[k]    = 1'b0;
                m_strobes[k] = 0;
            end else begin
                was_high = m_clk(k);
                if (m_rise[k]) m_strobes[k]++;
                m_acc[k]  = (m_acc[k] + P_FW[k]) % modulus;
                m_rise[k] = !was_high && m_clk(k);
            end
        end
    endtask

    task automatic cycle(input bit r);
        rst = r;
        @(posedge clk);
        #1;
        model_step(r);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if ({oc[k], rs[k], lk[k]} !== {m_clk(k), 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset dut%0d: got clk/rise/lock %b%b%b want %b00",
                         k, oc[k], rs[k], lk[k], m_clk(k));
            end
        end
        n_cmp++;
        if (oc[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_clk_zero: got %b want 0", oc[0]);
        end
        n_cmp++;
        if (oc[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_clk_phase: got %b want 1", oc[4]);
        end
    endtask

    // Half-rate and quarter-rate waveforms plus lock timing, from hand-derived edge numbers.
    task automatic test_rates;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        for (int e = 1; e <= 16; e++) begin
            cycle(1'b0);
            n_cmp++;
            if (oc[0] !== 1'(e % 2)) begin
                n_bad++;
                $display("FAIL half_clk edge %0d: got %b want %b", e, oc[0], 1'(e % 2));
            end
            n_cmp++;
            if (rs[0] !== 1'(e % 2)) begin
                n_bad++;
                $display("FAIL half_rise edge %0d: got %b want %b", e, rs[0], 1'(e % 2));
            end
            n_cmp++;
            if (lk[0] !== (e >= 8)) begin
                n_bad++;
                $display("FAIL half_lock edge %0d: got %b want %b", e, lk[0], e >= 8);
            end
            n_cmp++;
            if (oc[1] !== (e % 4 >= 2)) begin
                n_bad++;
                $display("FAIL quarter_clk edge %0d: got %b want %b", e, oc[1], e % 4 >= 2);
            end
            n_cmp++;
            if (rs[1] !== (e % 4 == 2)) begin
                n_bad++;
                $display("FAIL quarter_rise edge %0d: got %b want %b", e, rs[1], e % 4 == 2);
            end
        end
    endtask

    task automatic test_phase_offset;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        n_cmp++;
        if (oc[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL phase_reset_clk: got %b want 1", oc[4]);
        end
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b0);
            n_cmp++;
            if (rs[4] !== (e % 2 == 0)) begin
                n_bad++;
                $display("FAIL phase_rise edge %0d: got %b want %b", e, rs[4], e % 2 == 0);
            end
            n_cmp++;
            if (lk[4] !== (e >= 9)) begin
                n_bad++;
                $display("FAIL phase_lock edge %0d: got %b want %b", e, lk[4], e >= 9);
            end
        end
    endtask

    task automatic test_divide_by_three;
        int rises = 0;
        int run   = 0;
        int max_run = 0;
        bit last;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        last = oc[2];
        for (int e = 1; e <= 300; e++) begin
            cycle(1'b0);
            if (rs[2] === 1'b1) rises++;
            run = (oc[2] === last) ? run + 1 : 1;
            last = oc[2];
            if (run > max_run) max_run = run;
            n_cmp++;
            if ({oc[2], rs[2]} !== {m_clk(2), m_rise[2]}) begin
                n_bad++;
                $display("FAIL third_model edge %0d: got %b%b want %b%b",
                         e, oc[2], rs[2], m_clk(2), m_rise[2]);
            end
            n_cmp++;
            if ({oc[5], rs[5], lk[5]} !== {m_clk(5), m_rise[5], m_locked(5)}) begin
                n_bad++;
                $display("FAIL frac_model edge %0d: got %b%b%b want %b%b%b", e, oc[5], rs[5],
                         lk[5], m_clk(5), m_rise[5], m_locked(5));
            end
        end
        n_cmp++;
        if (rises < 99 || rises > 101) begin
            n_bad++;
            $display("FAIL third_rise_count: got %0d want 99..101", rises);
        end
        n_cmp++;
        if (max_run > 2) begin
            n_bad++;
            $display("FAIL third_max_phase: got %0d want <=2", max_run);
        end
    endtask

    task automatic test_zero_freq;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        for (int e = 1; e <= 1000; e++) begin
            cycle(1'b0);
            n_cmp++;
            if ({oc[3], rs[3], lk[3]} !== 3'b000) begin
                n_bad++;
                $display("FAIL zero_freq edge %0d: got %b%b%b want 000", e, oc[3], rs[3], lk[3]);
            end
        end
    endtask

    task automatic test_mid_reset;
        int n;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        n = 0;
        while (lk[0] !== 1'b1 && n < 50) begin
            cycle(1'b0);
            n++;
        end
        n_cmp++;
        if (lk[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_first_lock: got %b want 1 within 50 cycles", lk[0]);
        end
        n = 0;
        while (oc[0] !== 1'b1 && n < 4) begin
            cycle(1'b0);
            n++;
        end
        cycle(1'b1);
        n_cmp++;
        if ({oc[0], lk[0]} !== 2'b00) begin
            n_bad++;
            $display("FAIL midrst_clear: got clk/lock %b%b want 00", oc[0], lk[0]);
        end
        n = 0;
        while (lk[0] !== 1'b1 && n < 40) begin
            cycle(1'b0);
            n++;
        end
        n_cmp++;
        if (n != 8) begin
            n_bad++;
            $display("FAIL midrst_relock_edges: got %0d want 8", n);
        end
    endtask

    task automatic test_random;
        for (int b = 0; b < 25; b++) begin
            int rlen;
            int dlen;
            rlen = int'($urandom_range(1, 3));
            dlen = int'($urandom_range(1, 80));
            for (int c = 0; c < rlen + dlen; c++) begin
                cycle(c < rlen);
                for (int k = 0; k < N; k++) begin
                    n_cmp++;
                    if ({oc[k], rs[k], lk[k]} !== {m_clk(k), m_rise[k], m_locked(k)}) begin
                        n_bad++;
                        $display("FAIL random dut%0d burst %0d cyc %0d: got %b%b%b want %b%b%b",
                                 k, b, c, oc[k], rs[k], lk[k], m_clk(k), m_rise[k],
                                 m_locked(k));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_rates;
        test_phase_offset;
        test_divide_by_three;
        test_zero_freq;
        test_mid_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
